// File: rtl/ex_stage_md.sv
// Execute stage: operand forwarding, integer ALU, branch-target adder, EX/MEM register,
// plus an iterative radix-2 multiply/divide unit that stalls the front end while it runs.
//   state | meaning
//   IDLE  | no M op in flight; waiting for an M instruction in E
//   RUN   | one shift-add / restoring-divide step per cycle on operand magnitudes
//   DONE  | signs applied, result handed to the EX/MEM register
module ex_stage_md #(
  parameter int XLEN  = 32,
  parameter int MD_EN = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_e,
  input  logic [XLEN-1:0] rd1_e,
  input  logic [XLEN-1:0] rd2_e,
  input  logic [XLEN-1:0] imm_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] pcplus4_e,
  input  logic [4:0]      rd_e,
  input  logic [1:0]      forward_a_e,
  input  logic [1:0]      forward_b_e,
  input  logic [XLEN-1:0] result_w,
  input  logic            alu_src_a_e,
  input  logic            alu_src_b_e,
  input  logic [2:0]      alu_ctrl_e,
  input  logic            md_e,
  input  logic [2:0]      md_op_e,
  input  logic            flush_m,
  output logic            busy_e,
  output logic            zero_e,
  output logic [XLEN-1:0] pc_target_e,
  output logic [XLEN-1:0] alu_result_m,
  output logic [XLEN-1:0] write_data_m,
  output logic [XLEN-1:0] pcplus4_m,
  output logic [4:0]      rd_m,
  output logic            valid_m
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic MD = (MD_EN != 0);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} md_state_t;

  logic [XLEN-1:0] fwd_a, fwd_b, src_a, src_b, alu_out;

  always_comb begin
    case (forward_a_e)
      2'b01:   fwd_a = result_w;
      2'b10:   fwd_a = alu_result_m;
      default: fwd_a = rd1_e;
    endcase
    case (forward_b_e)
      2'b01:   fwd_b = result_w;
      2'b10:   fwd_b = alu_result_m;
      default: fwd_b = rd2_e;
    endcase
  end

  assign src_a = alu_src_a_e ? '0 : fwd_a;
  assign src_b = alu_src_b_e ? imm_e : fwd_b;

  always_comb begin
    alu_out = '0;
    case (alu_ctrl_e)
      3'b000:  alu_out = src_a + src_b;
      3'b001:  alu_out = src_a - src_b;
      3'b010:  alu_out = src_a & src_b;
      3'b011:  alu_out = src_a | src_b;
      3'b100:  alu_out = src_a ^ src_b;
      3'b101:  alu_out = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      3'b110:  alu_out = {{(XLEN-1){1'b0}}, src_a < src_b};
      default: alu_out = src_a << src_b[SW-1:0];
    endcase
  end

  assign zero_e      = (alu_out == '0);
  assign pc_target_e = pc_e + imm_e;

  md_state_t         state, state_nx;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, acc_mul, acc_div, prod_fix;
  logic [XLEN-1:0]   mag_b, mag_a_in, mag_b_in, quo, rem, md_result;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2:0]        op;
  logic              sign_a, sign_b, signed_a, signed_b, sa_in, sb_in, start;

  // Only operands treated as signed by the op contribute a sign; the rest are plain magnitudes.
  always_comb begin
    signed_a = md_op_e[2] ? ~md_op_e[0] : (md_op_e[1:0] == 2'b01 || md_op_e[1:0] == 2'b10);
    signed_b = md_op_e[2] ? ~md_op_e[0] : (md_op_e[1:0] == 2'b01);
    sa_in    = signed_a & fwd_a[XLEN-1];
    sb_in    = signed_b & fwd_b[XLEN-1];
    mag_a_in = sa_in ? -fwd_a : fwd_a;
    mag_b_in = sb_in ? -fwd_b : fwd_b;
  end

  assign start  = MD & valid_e & md_e & ~flush_m;
  assign busy_e = MD & reset & valid_e & md_e & (state != DONE) & ~flush_m;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (flush_m) state_nx = IDLE;
               else if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // acc holds {high/remainder, low/quotient}; the low half starts as |a| for both op kinds.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : '0);
    acc_mul   = {mul_sum, acc[XLEN-1:1]};
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, mag_b};
    acc_div   = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mag_b  <= '0;
      op     <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        acc    <= {{XLEN{1'b0}}, mag_a_in};
        mag_b  <= mag_b_in;
        op     <= md_op_e;
        sign_a <= sa_in;
        sign_b <= sb_in;
        cnt    <= '0;
      end else if (state == RUN) begin
        acc <= op[2] ? acc_div : acc_mul;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Divide by zero keeps an unnegated all-ones quotient; the remainder path already yields the dividend.
  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    quo      = acc[XLEN-1:0];
    rem      = acc[2*XLEN-1:XLEN];
    case (op)
      3'b000:                md_result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: md_result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:        md_result = (mag_b == '0) ? '1 : ((sign_a ^ sign_b) ? -quo : quo);
      default:               md_result = sign_a ? -rem : rem;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_result_m <= '0;
      write_data_m <= '0;
      pcplus4_m    <= '0;
      rd_m         <= '0;
      valid_m      <= 1'b0;
    end else if (busy_e || flush_m) begin
      alu_result_m <= '0;
      write_data_m <= '0;
      pcplus4_m    <= '0;
      rd_m         <= '0;
      valid_m      <= 1'b0;
    end else begin
      alu_result_m <= (state == DONE) ? md_result : alu_out;
      write_data_m <= fwd_b;
      pcplus4_m    <= pcplus4_e;
      rd_m         <= rd_e;
      valid_m      <= valid_e;
    end
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed bench for ex_stage_md: 32-bit and 64-bit instances with the M unit, and one without it.
module tb_ex_stage_md;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        va, vb, vc;
  logic [63:0] rd1, rd2, imm, pc, pcp4, resw;
  logic [4:0]  rd;
  logic [1:0]  fa, fb;
  logic        asel, bsel;
  logic [2:0]  actl, mop;
  logic        md, flush;

  logic        busy_a, zero_a, vm_a;
  logic [31:0] tgt_a, res_a, wd_a, p4_a;
  logic [4:0]  rdm_a;
  logic        busy_b, zero_b, vm_b;
  logic [63:0] tgt_b, res_b, wd_b, p4_b;
  logic [4:0]  rdm_b;
  logic        busy_c, zero_c, vm_c;
  logic [31:0] tgt_c, res_c, wd_c, p4_c;
  logic [4:0]  rdm_c;

  ex_stage_md #(.XLEN(32), .MD_EN(1)) d32 (
    .clk(clk), .reset(reset), .valid_e(va),
    .rd1_e(rd1[31:0]), .rd2_e(rd2[31:0]), .imm_e(imm[31:0]), .pc_e(pc[31:0]),
    .pcplus4_e(pcp4[31:0]), .rd_e(rd), .forward_a_e(fa), .forward_b_e(fb),
    .result_w(resw[31:0]), .alu_src_a_e(asel), .alu_src_b_e(bsel), .alu_ctrl_e(actl),
    .md_e(md), .md_op_e(mop), .flush_m(flush), .busy_e(busy_a), .zero_e(zero_a),
    .pc_target_e(tgt_a), .alu_result_m(res_a), .write_data_m(wd_a), .pcplus4_m(p4_a),
    .rd_m(rdm_a), .valid_m(vm_a));

  ex_stage_md #(.XLEN(64), .MD_EN(1)) d64 (
    .clk(clk), .reset(reset), .valid_e(vb),
    .rd1_e(rd1), .rd2_e(rd2), .imm_e(imm), .pc_e(pc),
    .pcplus4_e(pcp4), .rd_e(rd), .forward_a_e(fa), .forward_b_e(fb),
    .result_w(resw), .alu_src_a_e(asel), .alu_src_b_e(bsel), .alu_ctrl_e(actl),
    .md_e(md), .md_op_e(mop), .flush_m(flush), .busy_e(busy_b), .zero_e(zero_b),
    .pc_target_e(tgt_b), .alu_result_m(res_b), .write_data_m(wd_b), .pcplus4_m(p4_b),
    .rd_m(rdm_b), .valid_m(vm_b));

  ex_stage_md #(.XLEN(32), .MD_EN(0)) dnomd (
    .clk(clk), .reset(reset), .valid_e(vc),
    .rd1_e(rd1[31:0]), .rd2_e(rd2[31:0]), .imm_e(imm[31:0]), .pc_e(pc[31:0]),
    .pcplus4_e(pcp4[31:0]), .rd_e(rd), .forward_a_e(fa), .forward_b_e(fb),
    .result_w(resw[31:0]), .alu_src_a_e(asel), .alu_src_b_e(bsel), .alu_ctrl_e(actl),
    .md_e(md), .md_op_e(mop), .flush_m(flush), .busy_e(busy_c), .zero_e(zero_c),
    .pc_target_e(tgt_c), .alu_result_m(res_c), .write_data_m(wd_c), .pcplus4_m(p4_c),
    .rd_m(rdm_c), .valid_m(vm_c));

  int total = 0;
  int bad = 0;
  int k = 1;
  logic [63:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
    end else begin
      e = sb.pop_front();
      chk(tag, obs, e);
    end
  endtask

  // ALU instruction on the 32-bit instance; called just after a falling edge, returns on the next one.
  task automatic alu(input string tag, input logic [2:0] op, input logic za, input logic bi,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                     input logic [31:0] exp);
    logic [4:0] r;
    r = 5'(k);
    k++;
    va = 1'b1; md = 1'b0; actl = op; asel = za; bsel = bi;
    rd1 = {32'b0, a}; rd2 = {32'b0, b}; imm = {32'b0, im}; rd = r;
    sb.push_back({32'b0, exp});
    #1;
    chk({tag, "_zero"}, 64'(zero_a), 64'(exp == 32'b0));
    @(negedge clk);
    pop_chk(tag, {32'b0, res_a});
    chk({tag, "_vm"}, 64'(vm_a), 64'd1);
    chk({tag, "_rd"}, 64'(rdm_a), 64'(r));
  endtask

  // M instruction on the 32-bit (w=0) or 64-bit (w=1) instance; operands are scrambled during the stall.
  task automatic mdop(input logic w, input string tag, input logic [2:0] op,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
    int n;
    int xl;
    logic [4:0] r;
    xl = w ? 64 : 32;
    r = 5'(k);
    k++;
    va = ~w; vb = w; md = 1'b1; mop = op; fa = 2'b00; fb = 2'b00;
    rd1 = a; rd2 = b; rd = r;
    sb.push_back(exp);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (!(w ? busy_b : busy_a)) break;
      n++;
      @(negedge clk);
      if (i == 0) begin
        rd1 = ~a;
        rd2 = ~b ^ 64'h5;
      end
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'(xl + 1));
    chk({tag, "_done_bubble"}, 64'(w ? vm_b : vm_a), 64'd0);
    @(negedge clk);
    pop_chk(tag, w ? res_b : {32'b0, res_a});
    chk({tag, "_vm"}, 64'(w ? vm_b : vm_a), 64'd1);
    chk({tag, "_rd"}, 64'(w ? rdm_b : rdm_a), 64'(r));
    va = 1'b0; vb = 1'b0; md = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    va = 0; vb = 0; vc = 0; md = 0; flush = 0;
    rd1 = 0; rd2 = 0; imm = 0; pc = 0; pcp4 = 0; resw = 0; rd = 0;
    fa = 0; fb = 0; asel = 0; bsel = 0; actl = 0; mop = 0;
    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy32", 64'(busy_a), 64'd0);
    chk("rst_res32", {32'b0, res_a}, 64'd0);
    chk("rst_vm32", 64'(vm_a), 64'd0);
    chk("rst_rd32", 64'(rdm_a), 64'd0);
    chk("rst_busy64", 64'(busy_b), 64'd0);
    chk("rst_vm64", 64'(vm_b), 64'd0);
    reset = 1'b1;

    alu("add_imm", 3'b000, 1'b0, 1'b1, 32'd3, 32'd0, 32'd4, 32'd7);
    fa = 2'b10;
    alu("fwd_a_m", 3'b000, 1'b0, 1'b1, 32'd5, 32'd0, 32'd3, 32'd10);
    fa = 2'b00; fb = 2'b01; resw = 64'h20;
    alu("fwd_b_w", 3'b000, 1'b0, 1'b0, 32'd1, 32'd9, 32'd0, 32'h21);
    chk("fwd_b_wdata", {32'b0, wd_a}, 64'h20);
    fb = 2'b00;
    alu("sub", 3'b001, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 32'hFFFF_FFFE);
    alu("and", 3'b010, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'hF000_F000);
    alu("or", 3'b011, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'hFFF0_FFF0);
    alu("xor", 3'b100, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'h0FF0_0FF0);
    alu("slt", 3'b101, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1);
    alu("sltu", 3'b110, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    alu("slt_min", 3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'd0, 32'd0, 32'd1);
    alu("sll31", 3'b111, 1'b0, 1'b0, 32'd1, 32'h3F, 32'd0, 32'h8000_0000);
    alu("add_zero", 3'b000, 1'b0, 1'b0, 32'd5, 32'hFFFF_FFFB, 32'd0, 32'd0);
    pc = 64'h1000; pcp4 = 64'h1004;
    alu("src_a_zero", 3'b000, 1'b1, 1'b1, 32'hDEAD, 32'd0, 32'h1234_5000, 32'h1234_5000);
    chk("pc_target", {32'b0, tgt_a}, 64'h1234_6000);
    chk("pcplus4_m", {32'b0, p4_a}, 64'h1004);

    va = 1'b0;
    reset = 1'b0;
    #1;
    chk("async_rst_res", {32'b0, res_a}, 64'd0);
    chk("async_rst_vm", 64'(vm_a), 64'd0);
    chk("async_rst_rd", 64'(rdm_a), 64'd0);
    chk("async_rst_p4", {32'b0, p4_a}, 64'd0);
    #1 reset = 1'b1;
    @(negedge clk);

    mdop(1'b0, "mul", 3'b000, 64'hFFFF_FFFF, 64'd2, 64'hFFFF_FFFE);
    mdop(1'b0, "mulh", 3'b001, 64'hFFFF_FFFF, 64'd2, 64'hFFFF_FFFF);
    mdop(1'b0, "mulhsu", 3'b010, 64'hFFFF_FFFF, 64'd2, 64'hFFFF_FFFF);
    mdop(1'b0, "mulhu", 3'b011, 64'hFFFF_FFFF, 64'd2, 64'h1);
    mdop(1'b0, "div_by0", 3'b100, 64'd7, 64'd0, 64'hFFFF_FFFF);
    mdop(1'b0, "rem_by0", 3'b110, 64'd7, 64'd0, 64'd7);
    mdop(1'b0, "div_ovf", 3'b100, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000);
    mdop(1'b0, "rem_ovf", 3'b110, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0);
    mdop(1'b0, "div_neg", 3'b100, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD);
    mdop(1'b0, "rem_neg", 3'b110, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF);

    va = 1'b1; md = 1'b1; mop = 3'b000; rd1 = 64'd9; rd2 = 64'd9;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_run_busy", 64'(busy_a), 64'd0);
    @(negedge clk);
    chk("flush_run_bubble", 64'(vm_a), 64'd0);
    flush = 1'b0;
    mdop(1'b0, "divu_after_flush", 3'b101, 64'd100, 64'd7, 64'd14);
    mdop(1'b0, "remu_after_flush", 3'b111, 64'd100, 64'd7, 64'd2);

    va = 1'b1; md = 1'b1; mop = 3'b000; rd1 = 64'd3; rd2 = 64'd5; flush = 1'b1;
    #1;
    chk("flush_start_busy", 64'(busy_a), 64'd0);
    @(negedge clk);
    chk("flush_start_bubble", 64'(vm_a), 64'd0);
    flush = 1'b0;
    mdop(1'b0, "mul_after_flush", 3'b000, 64'd3, 64'd5, 64'd15);

    va = 1'b1; md = 1'b1; mop = 3'b000; rd1 = 64'd6; rd2 = 64'd7;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midmul_rst_busy", 64'(busy_a), 64'd0);
    chk("midmul_rst_vm", 64'(vm_a), 64'd0);
    chk("midmul_rst_res", {32'b0, res_a}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    alu("add_after_rst", 3'b000, 1'b0, 1'b0, 32'd40, 32'd2, 32'd0, 32'd42);
    mdop(1'b0, "mul_after_rst", 3'b000, 64'd6, 64'd7, 64'd42);

    mdop(1'b1, "mulhu64", 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
         64'hFFFF_FFFF_FFFF_FFFE);

    vc = 1'b1; md = 1'b1; mop = 3'b100; actl = 3'b000; asel = 1'b0; bsel = 1'b0;
    fa = 2'b00; fb = 2'b00; rd1 = 64'd3; rd2 = 64'd4; rd = 5'd9;
    #1;
    chk("nomd_busy", 64'(busy_c), 64'd0);
    @(negedge clk);
    chk("nomd_busy_held", 64'(busy_c), 64'd0);
    chk("nomd_res", {32'b0, res_c}, 64'd7);
    chk("nomd_vm", 64'(vm_c), 64'd1);
    vc = 1'b0; md = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
